// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared MAR/MDR/memory port; sequences one transfer's strobes.
// Grant appears the cycle after the request edge; strobes and ack are registered Moore outputs.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_ex,
  input  logic ex_rw,
  input  logic MFC,
  output logic gnt_if,
  output logic gnt_ex,
  output logic MARin,
  output logic MDRwriteEN,
  output logic memEN,
  output logic RW,
  output logic MDRreadEN,
  output logic ack_if,
  output logic ack_ex,
  output logic err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state, state_nxt;
  logic             owner_if, owner_if_nxt;   // 1 = IF owns the bus, 0 = EX
  logic             dir, dir_nxt;             // 1 = read, 0 = write
  logic             last_if, last_if_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pick_if;

  always_comb begin
    state_nxt    = state;
    owner_if_nxt = owner_if;
    dir_nxt      = dir;
    last_if_nxt  = last_if;
    cnt_nxt      = cnt;
    pick_if      = req_if && (!req_ex || !last_if);
    case (state)
      S_IDLE: begin
        if (req_if || req_ex) begin
          owner_if_nxt = pick_if;
          dir_nxt      = pick_if ? 1'b1 : ex_rw;
          last_if_nxt  = pick_if;
          state_nxt    = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_nxt   = '0;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // MFC takes priority over a timeout landing on the same edge
        if (MFC) begin
          state_nxt = dir ? S_CAPTURE : S_DONE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner_if   <= 1'b0;
      dir        <= 1'b0;
      last_if    <= 1'b0;
      cnt        <= '0;
      gnt_if     <= 1'b0;
      gnt_ex     <= 1'b0;
      MARin      <= 1'b0;
      MDRwriteEN <= 1'b0;
      memEN      <= 1'b0;
      RW         <= 1'b0;
      MDRreadEN  <= 1'b0;
      ack_if     <= 1'b0;
      ack_ex     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_if   <= owner_if_nxt;
      dir        <= dir_nxt;
      last_if    <= last_if_nxt;
      cnt        <= cnt_nxt;
      // outputs decoded from the next state so they are flops aligned with the state
      gnt_if     <= (state_nxt != S_IDLE) && owner_if_nxt;
      gnt_ex     <= (state_nxt != S_IDLE) && !owner_if_nxt;
      MARin      <= (state_nxt == S_ADDR);
      MDRwriteEN <= (state_nxt == S_ADDR) && !dir_nxt;
      memEN      <= (state_nxt == S_ACCESS) || (state_nxt == S_CAPTURE);
      RW         <= (state_nxt == S_CAPTURE) ||
                    (((state_nxt == S_ACCESS) || (state_nxt == S_DONE)) && dir_nxt);
      MDRreadEN  <= (state_nxt == S_CAPTURE);
      ack_if     <= ((state_nxt == S_DONE) || (state_nxt == S_ERR)) && owner_if_nxt;
      ack_ex     <= ((state_nxt == S_DONE) || (state_nxt == S_ERR)) && !owner_if_nxt;
      err        <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-transfer expected strobe sequences from a transaction model.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  localparam logic [9:0] G_IF = 10'b1000000000;
  localparam logic [9:0] G_EX = 10'b0100000000;
  localparam logic [9:0] MAR  = 10'b0010000000;
  localparam logic [9:0] MDRW = 10'b0001000000;
  localparam logic [9:0] MEN  = 10'b0000100000;
  localparam logic [9:0] RWB  = 10'b0000010000;
  localparam logic [9:0] MDRR = 10'b0000001000;
  localparam logic [9:0] AIF  = 10'b0000000100;
  localparam logic [9:0] AEX  = 10'b0000000010;
  localparam logic [9:0] ERRB = 10'b0000000001;

  logic clk = 1'b0;
  logic rst, req_if, req_ex, ex_rw, MFC;
  logic gnt_if, gnt_ex, MARin, MDRwriteEN, memEN, RW, MDRreadEN, ack_if, ack_ex, err;

  int compared = 0;
  int mismatched = 0;
  bit last_if;   // model of last owner: 1 = IF, 0 = EX

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req_if(req_if), .req_ex(req_ex), .ex_rw(ex_rw), .MFC(MFC),
    .gnt_if(gnt_if), .gnt_ex(gnt_ex), .MARin(MARin), .MDRwriteEN(MDRwriteEN),
    .memEN(memEN), .RW(RW), .MDRreadEN(MDRreadEN), .ack_if(ack_if), .ack_ex(ack_ex),
    .err(err)
  );

  function automatic logic [9:0] obs();
    return {gnt_if, gnt_ex, MARin, MDRwriteEN, memEN, RW, MDRreadEN, ack_if, ack_ex, err};
  endfunction

  // Called at a negedge during an IDLE cycle. mfc_at = ACCESS cycle (1-based) where MFC rises;
  // outside 1..TO the transfer times out.
  task automatic do_transfer(input string name, input bit rif, input bit rex,
                             input bit rw, input int mfc_at);
    bit own_if, dir, ok;
    int n;
    logic [9:0] g, ack;
    logic [9:0] exp[$];
    req_if = rif;
    req_ex = rex;
    ex_rw  = rw;
    MFC    = 1'($urandom);
    own_if = (rif && rex) ? !last_if : rif;
    last_if = own_if;
    dir = own_if ? 1'b1 : rw;
    g   = own_if ? G_IF : G_EX;
    ack = own_if ? AIF : AEX;
    ok  = (mfc_at >= 1) && (mfc_at <= TO);
    n   = ok ? mfc_at : TO;
    exp.push_back(g | MAR | (dir ? 10'b0 : MDRW));
    repeat (n) exp.push_back(g | MEN | (dir ? RWB : 10'b0));
    if (ok && dir) exp.push_back(g | MEN | RWB | MDRR);
    if (ok) exp.push_back(g | (dir ? RWB : 10'b0) | ack);
    else    exp.push_back(g | ack | ERRB);
    exp.push_back(10'b0);
    foreach (exp[i]) begin
      @(negedge clk);
      compared++;
      if (obs() !== exp[i]) begin
        mismatched++;
        $display("FAIL %s cycle %0d: got %b want %b (gif gex mar mdrw men rw mdrr aif aex err)",
                 name, i + 1, obs(), exp[i]);
      end
      ex_rw = 1'($urandom);
      MFC = (i >= 1 && i <= n) ? (i == mfc_at) : 1'($urandom);
      if (i < exp.size() - 2) begin
        if (own_if) req_ex = 1'($urandom);
        else        req_if = 1'($urandom);
      end else if (i == exp.size() - 2) begin
        if (own_if) begin req_if = 1'b0; req_ex = rex; end
        else        begin req_ex = 1'b0; req_if = rif; end
      end else begin
        req_if = 1'b0;
        req_ex = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int cycles);
    req_if = 1'b0;
    req_ex = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      MFC   = 1'($urandom);
      ex_rw = 1'($urandom);
      @(negedge clk);
      compared++;
      if (obs() !== 10'b0) begin
        mismatched++;
        $display("FAIL idle cycle %0d: got %b want %b", i, obs(), 10'b0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_if = 1'b1;
    req_ex = 1'b1;
    repeat (2) begin
      @(negedge clk);
      compared++;
      if (obs() !== 10'b0) begin
        mismatched++;
        $display("FAIL reset_outputs: got %b want %b", obs(), 10'b0);
      end
    end
    rst = 1'b1;
    last_if = 1'b0;
    do_transfer("reset_first_tie", 1'b1, 1'b1, 1'b0, 1);
  endtask

  task automatic test_if_read();
    do_transfer("if_read", 1'b1, 1'b0, 1'b0, 1);
  endtask

  task automatic test_ex_write();
    do_transfer("ex_write", 1'b0, 1'b1, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      do_transfer("back_to_back", 1'b1, 1'b1, 1'($urandom), int'($urandom_range(1, TO)));
  endtask

  task automatic test_timeout();
    do_transfer("timeout", 1'b0, 1'b1, 1'($urandom), 0);
    do_transfer("after_timeout", 1'b0, 1'b1, 1'b1, 2);
  endtask

  task automatic test_mid_reset();
    req_if = 1'b1;
    req_ex = 1'b0;
    MFC    = 1'b0;
    @(negedge clk);
    compared++;
    if (obs() !== (G_IF | MAR)) begin
      mismatched++;
      $display("FAIL mid_reset_addr: got %b want %b", obs(), G_IF | MAR);
    end
    @(negedge clk);
    compared++;
    if (obs() !== (G_IF | MEN | RWB)) begin
      mismatched++;
      $display("FAIL mid_reset_access: got %b want %b", obs(), G_IF | MEN | RWB);
    end
    rst = 1'b0;
    req_ex = 1'b1;
    @(negedge clk);
    compared++;
    if (obs() !== 10'b0) begin
      mismatched++;
      $display("FAIL mid_reset_drop: got %b want %b", obs(), 10'b0);
    end
    rst = 1'b1;
    last_if = 1'b0;
    do_transfer("post_reset_tie", 1'b1, 1'b1, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) idle_check(int'($urandom_range(1, 3)));
      do_transfer("random", sel[0], sel[1], 1'($urandom), int'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    rst = 1'b0;
    req_if = 1'b0;
    req_ex = 1'b0;
    ex_rw = 1'b0;
    MFC = 1'b0;
    last_if = 1'b0;
    @(negedge clk);
    test_reset();
    idle_check(2);
    test_if_read();
    test_ex_write();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single MAR/MDR/memory port between two requesters: the instruction fetch sequencer (IF) and the execute unit's load/store path (EX).
- Arbitrates round-robin between them, then sequences the bus-control strobes for one transfer:
  - drives the grant, which selects the address source;
  - issues the MAR load, memory enable and RW;
  - waits for MFC, with a timeout;
  - issues the MDR capture strobe;
  - returns a one-cycle acknowledge.
- Sits between the requester FSMs and the memory/MAR/MDR datapath, and replaces their direct strobe drive.

Parameters:
TIMEOUT, 16, max ACCESS cycles to wait for MFC before abort; 0 disables the timeout.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-low reset (sampled on rising clk edge)
req_if  in  1  IF transfer request; always a read
req_ex  in  1  EX transfer request
ex_rw  in  1  EX direction: 1 = read, 0 = write; sampled at grant
MFC  in  1  memory function complete
gnt_if  out  1  IF owns bus; enables PC onto address bus
gnt_ex  out  1  EX owns bus; enables EX address onto address bus
MARin  out  1  load MAR
MDRwriteEN  out  1  load MDR from EX write data (writes only)
memEN  out  1  memory enable
RW  out  1  1 = read, 0 = write; valid while memEN is high
MDRreadEN  out  1  capture memory data into MDR (reads only)
ack_if  out  1  one-cycle transfer complete to IF
ack_ex  out  1  one-cycle transfer complete to EX
err  out  1  one-cycle timeout flag, coincident with the ack

Behaviour:
- All outputs are registered Moore outputs decoded from the state plus the registered owner/direction.
- Reset (rst = 0 at an edge):
  - state goes to IDLE; all outputs 0; timeout counter 0; last-owner = EX.
  - Reset mid-transfer aborts the transfer; no ack is issued.
- IDLE:
  - No requests: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that is not last-owner, so IF wins the first tie after reset.
  - On grant: latch owner; latch dir (IF forces read; EX uses ex_rw); update last-owner; go to ADDR.
- ADDR (1 cycle):
  - gnt_x = 1, MARin = 1.
  - MDRwriteEN = 1 if dir is write.
  - Go to ACCESS; clear the counter.
- ACCESS:
  - gnt_x = 1, memEN = 1, RW = dir.
  - MFC sampled high: go to CAPTURE if read, to DONE if write.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with MFC low, go to ERR.
  - MFC high on the same edge as the timeout: MFC wins.
- CAPTURE (1 cycle, reads only): gnt_x = 1, memEN = 1, RW = 1, MDRreadEN = 1; go to DONE.
- DONE (1 cycle): gnt_x = 1, RW = dir, ack_x = 1; go to IDLE.
- ERR (1 cycle): gnt_x = 1, ack_x = 1, err = 1, memEN = 0; go to IDLE.
- Grants:
  - gnt_if and gnt_ex are never high together.
  - The grant is held from ADDR through DONE/ERR inclusive.
- Handshake rules:
  - A requester holds req high until it sees its ack, then deasserts req on the edge that ends the ack cycle.
  - A requester that keeps req high re-enters arbitration from IDLE.
  - Back-to-back requests always spend one IDLE cycle between transfers.
- Ignored inputs:
  - req_if/req_ex/ex_rw changes after grant are ignored until IDLE.
  - MFC is ignored outside ACCESS.
- Latency: req sampled at edge N gives ADDR in cycle N+1. For a read with MFC high in its first ACCESS cycle, ack appears in cycle N+4; for a write, in cycle N+3.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both reqs high -> all outputs 0, state IDLE. After release, gnt_if is granted first.
- IF read, MFC high on the 1st ACCESS cycle -> per-cycle strobes:
  - cycle 1: MARin;
  - cycle 2: memEN, RW = 1;
  - cycle 3: MDRreadEN;
  - cycle 4: ack_if.
  - gnt_if is high in cycles 1-4; err = 0.
- EX write (ex_rw = 0), MFC after 3 ACCESS cycles -> MDRwriteEN with MARin; memEN with RW = 0 for 3 cycles; no MDRreadEN; ack_ex one cycle later.
- Both reqs held continuously for 4 transfers -> grant order IF, EX, IF, EX; grants never overlap; one IDLE cycle between transfers.
- Timeout: TIMEOUT = 4, MFC never asserted -> memEN high for exactly 4 cycles, then a one-cycle ack + err pulse; next transfer proceeds normally.
- Reset mid-ACCESS (rst = 0 for 1 cycle) -> memEN and grant drop at that edge; no ack; last-owner = EX, so the following tie goes to IF.
